divider_step_controller: RTL and testbench
==========================================

DIVIDER_STEP_CONTROLLER -- requirements
Module: divider_step_controller

Interface
REQ-001 Parameter MAX_DIVISION, default 10: divider wrap limit; legal half-divisors are 1..MAX_DIVISION/2 (MAX_HALF).
REQ-002 Parameter DIVISOR_RANGE, default 6: width of all half-divisor ports.
REQ-003 Parameter PULSE_CYCLES, default 4: clock_in cycles that step_divisor is held high per step (>=1).
REQ-004 Parameter GAP_CYCLES, default 4: clock_in cycles that step_divisor is held low after each high phase (>=1).
REQ-005 clock_in  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req_valid  input  1  host requests a new half-divisor.
REQ-008 req_half_divisor  input  DIVISOR_RANGE  requested target half-divisor.
REQ-009 req_ready  output  1  controller can accept a request this cycle.
REQ-010 step_divisor  output  1  registered step pulse to the divider's step_divisor input.
REQ-011 busy  output  1  step sequence in progress.
REQ-012 done  output  1  one-cycle pulse: sequence finished, divider at target.
REQ-013 error  output  1  one-cycle pulse: request rejected as out of range.
REQ-014 current_half_divisor  output  DIVISOR_RANGE  controller's model of the divider's half-divisor.

Function
REQ-015 FSM states SHALL be IDLE, HIGH, LOW, FINISH; req_ready SHALL equal (state==IDLE); busy SHALL equal (state!=IDLE).
REQ-016 Request accepted on a rising edge where req_valid && req_ready; req_half_divisor is sampled only then.
REQ-017 Target 0 or > MAX_HALF SHALL be rejected: error high the next cycle, state stays IDLE, no step pulse, model unchanged.
REQ-018 Target equal to current_half_divisor SHALL go IDLE->FINISH: done high the next cycle, zero step pulses.
REQ-019 Otherwise step count N = (target - current) mod MAX_HALF, computed with wrap (e.g. MAX_HALF=5: 4->2 gives N=3, path 4,5,1,2), latched at acceptance; range 1..MAX_HALF-1.
REQ-020 IDLE->HIGH on acceptance; step_divisor SHALL be high exactly PULSE_CYCLES cycles in HIGH, then low exactly GAP_CYCLES cycles in LOW.
REQ-021 On entering HIGH, current_half_divisor SHALL advance by one, wrapping MAX_HALF->1, mirroring the divider's rising-edge increment.
REQ-022 LOW->HIGH while steps remain; LOW->FINISH after the N-th gap; FINISH lasts one cycle with done high, then IDLE.
REQ-023 Total accept-to-done latency SHALL be N*(PULSE_CYCLES+GAP_CYCLES)+1 cycles for N>=1, 1 cycle for N=0.
REQ-024 req_valid while busy SHALL be ignored (not queued); host must hold req_valid until req_ready.
REQ-025 step_divisor SHALL be driven directly from a flop, never glitch, and never be high outside HIGH.
REQ-026 All arithmetic SHALL be DIVISOR_RANGE bits wide with no truncation for MAX_HALF < 2^DIVISOR_RANGE.

Reset
REQ-027 Reset SHALL asynchronously force state IDLE, step_divisor 0, done 0, error 0, busy 0, counters 0.
REQ-028 Reset SHALL set current_half_divisor to 1, matching the divider power-up value; req_ready high after release.
REQ-029 Reset during HIGH SHALL drop step_divisor in the same instant; the partial pulse is not counted and no done is issued.

Structure
REQ-030 Shared package SHALL hold the FSM state encoding, MAX_HALF derivation and default parameter constants.
REQ-031 One sub-module, step_phase_timer, SHALL count PULSE_CYCLES/GAP_CYCLES and flag phase end; the step counter and model stay in the top.

Verification
REQ-032 Reset, request 3 from model 1 -> two pulses of 4 high/4 low, model 2 then 3, done at cycle 17 after acceptance.
REQ-033 Model 4, request 2 (MAX_DIVISION=10) -> three pulses, model 5,1,2, done once, busy high throughout.
REQ-034 Request equal to model (1) -> no pulse, done next cycle, req_ready high again the cycle after.
REQ-035 Requests 0 and 6 -> error pulse each, no step_divisor activity, model unchanged.
REQ-036 New req_valid while busy -> ignored, original sequence completes unchanged.
REQ-037 Assert reset mid-HIGH -> step_divisor low immediately, model 1, no done; fresh request after release runs normally.

Source files
------------

// File: rtl/divider_step_controller_pkg.sv
// Shared definitions for the divider step controller.
// Holds the FSM state encoding, the default parameter constants and the
// derivation of the largest legal half-divisor from the divider wrap limit.
package divider_step_controller_pkg;

  localparam int DEFAULT_MAX_DIVISION  = 10;
  localparam int DEFAULT_DIVISOR_RANGE = 6;
  localparam int DEFAULT_PULSE_CYCLES  = 4;
  localparam int DEFAULT_GAP_CYCLES    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HIGH   = 2'd1,
    LOW    = 2'd2,
    FINISH = 2'd3
  } state_e;

  // Largest half-divisor the divider reaches before wrapping back to 1.
  function automatic int max_half_f(input int max_division);
    return max_division / 2;
  endfunction

endpackage

// File: rtl/divider_step_controller_step_phase_timer.sv
// Phase timer for the step sequence.
// Counts clock_in cycles within the current high or low phase and flags the
// last cycle of that phase so the controller can move on.
// Ports:
//   clock_in    rising-edge clock
//   reset       asynchronous active-high reset
//   run         a high or low phase is in progress
//   high_phase  1 = timing the high phase, 0 = timing the low phase
//   phase_end   combinational flag: this is the final cycle of the phase
module step_phase_timer
  import divider_step_controller_pkg::*;
#(
  parameter int PULSE_CYCLES = DEFAULT_PULSE_CYCLES,
  parameter int GAP_CYCLES   = DEFAULT_GAP_CYCLES
) (
  input  logic clock_in,
  input  logic reset,
  input  logic run,
  input  logic high_phase,
  output logic phase_end
);

  localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] limit_s;

  // Select the terminal count for the active phase and flag its last cycle.
  always_comb begin
    limit_s   = {CNT_W{1'b0}};
    phase_end = 1'b0;
    if (high_phase) begin
      limit_s = CNT_W'(PULSE_CYCLES - 1);
    end else begin
      limit_s = CNT_W'(GAP_CYCLES - 1);
    end
    if (run) begin
      phase_end = (cnt_r == limit_s);
    end else begin
      phase_end = 1'b0;
    end
  end

  // Cycle counter; restarts at every phase boundary and whenever idle.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!run || phase_end) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/divider_step_controller.sv
// Divider step controller.
// Walks an external clock divider from its current half-divisor to a
// requested one by issuing step pulses (one increment per pulse, wrapping
// MAX_HALF -> 1), while keeping a model of the divider's half-divisor.
// Ports:
//   clock_in              rising-edge clock
//   reset                 asynchronous active-high reset
//   req_valid             host requests a new half-divisor
//   req_half_divisor      requested target half-divisor
//   req_ready             controller idle, request accepted this cycle
//   step_divisor          registered step pulse to the divider
//   busy                  step sequence in progress
//   done                  one-cycle pulse, divider now at target
//   error                 one-cycle pulse, request out of range
//   current_half_divisor  model of the divider's half-divisor
module divider_step_controller
  import divider_step_controller_pkg::*;
#(
  parameter int MAX_DIVISION  = DEFAULT_MAX_DIVISION,
  parameter int DIVISOR_RANGE = DEFAULT_DIVISOR_RANGE,
  parameter int PULSE_CYCLES  = DEFAULT_PULSE_CYCLES,
  parameter int GAP_CYCLES    = DEFAULT_GAP_CYCLES
) (
  input  logic                     clock_in,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [DIVISOR_RANGE-1:0] req_half_divisor,
  output logic                     req_ready,
  output logic                     step_divisor,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [DIVISOR_RANGE-1:0] current_half_divisor
);

  localparam logic [DIVISOR_RANGE-1:0] MAX_HALF = DIVISOR_RANGE'(max_half_f(MAX_DIVISION));
  localparam logic [DIVISOR_RANGE-1:0] ONE      = DIVISOR_RANGE'(1);
  localparam logic [DIVISOR_RANGE-1:0] ZERO     = DIVISOR_RANGE'(0);

  state_e                     state_r;
  state_e                     next_state_s;
  logic [DIVISOR_RANGE-1:0]   steps_left_r;
  logic [DIVISOR_RANGE-1:0]   current_r;
  logic [DIVISOR_RANGE-1:0]   step_count_s;
  logic [DIVISOR_RANGE-1:0]   next_model_s;
  logic                       step_r;
  logic                       done_r;
  logic                       error_r;
  logic                       busy_r;
  logic                       ready_r;
  logic                       accept_s;
  logic                       reject_s;
  logic                       match_s;
  logic                       run_s;
  logic                       high_phase_s;
  logic                       phase_end_s;

  step_phase_timer #(
    .PULSE_CYCLES (PULSE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) u_timer (
    .clock_in   (clock_in),
    .reset      (reset),
    .run        (run_s),
    .high_phase (high_phase_s),
    .phase_end  (phase_end_s)
  );

  // Request decode, wrapped step distance and the model's next value.
  always_comb begin
    accept_s     = req_valid && (state_r == IDLE);
    reject_s     = (req_half_divisor == ZERO) || (req_half_divisor > MAX_HALF);
    match_s      = (req_half_divisor == current_r);
    run_s        = (state_r == HIGH) || (state_r == LOW);
    high_phase_s = (state_r == HIGH);
    // Going backwards wraps through MAX_HALF; ordering the terms this way
    // keeps every intermediate below MAX_HALF, so nothing overflows.
    if (req_half_divisor > current_r) begin
      step_count_s = req_half_divisor - current_r;
    end else begin
      step_count_s = (MAX_HALF - current_r) + req_half_divisor;
    end
    if (current_r == MAX_HALF) begin
      next_model_s = ONE;
    end else begin
      next_model_s = current_r + ONE;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !reject_s && match_s) begin
          next_state_s = FINISH;
        end else if (accept_s && !reject_s) begin
          next_state_s = HIGH;
        end else begin
          next_state_s = IDLE;
        end
      end
      HIGH: begin
        if (phase_end_s) begin
          next_state_s = LOW;
        end else begin
          next_state_s = HIGH;
        end
      end
      LOW: begin
        if (phase_end_s && (steps_left_r <= ONE)) begin
          next_state_s = FINISH;
        end else if (phase_end_s) begin
          next_state_s = HIGH;
        end else begin
          next_state_s = LOW;
        end
      end
      FINISH:  next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Output flops decoded from the next state so they line up with state_r;
  // step_divisor therefore comes straight from a flop and is high only in HIGH.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      step_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
      busy_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      step_r  <= (next_state_s == HIGH);
      done_r  <= (next_state_s == FINISH);
      error_r <= accept_s && reject_s;
      busy_r  <= (next_state_s != IDLE);
      ready_r <= (next_state_s == IDLE);
    end
  end

  // Divider model: advances as each high phase starts, like the divider does
  // on the rising edge of step_divisor.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      current_r <= ONE;
    end else if ((next_state_s == HIGH) && (state_r != HIGH)) begin
      current_r <= next_model_s;
    end else begin
      current_r <= current_r;
    end
  end

  // Remaining steps: latched on acceptance, decremented at each gap end.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      steps_left_r <= ZERO;
    end else if (accept_s && !reject_s && !match_s) begin
      steps_left_r <= step_count_s;
    end else if ((state_r == LOW) && phase_end_s && (steps_left_r != ZERO)) begin
      steps_left_r <= steps_left_r - ONE;
    end else begin
      steps_left_r <= steps_left_r;
    end
  end

  assign req_ready            = ready_r;
  assign step_divisor         = step_r;
  assign busy                 = busy_r;
  assign done                 = done_r;
  assign error                = error_r;
  assign current_half_divisor = current_r;

endmodule

// File: tb/tb_divider_step_controller.sv
// Self-checking bench for divider_step_controller with default parameters
// (MAX_HALF = 5, 4 cycles high / 4 cycles low per step).
module tb_divider_step_controller;

  logic       clock_in = 1'b0;
  logic       reset    = 1'b1;
  logic       req_valid = 1'b0;
  logic [5:0] req_half_divisor = 6'd0;
  logic       req_ready;
  logic       step_divisor;
  logic       busy;
  logic       done;
  logic       error;
  logic [5:0] current_half_divisor;

  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] model_q = 6'd1;

  typedef struct {
    logic [5:0] req;
    bit         exp_err;
    int         exp_n;
    logic [5:0] exp_model;
  } vec_t;

  typedef struct {
    bit         err;
    logic [5:0] model;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[11];

  divider_step_controller dut (
    .clock_in             (clock_in),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_half_divisor     (req_half_divisor),
    .req_ready            (req_ready),
    .step_divisor         (step_divisor),
    .busy                 (busy),
    .done                 (done),
    .error                (error),
    .current_half_divisor (current_half_divisor)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] adv(input logic [5:0] m, input int n);
    logic [5:0] r;
    r = m;
    for (int i = 0; i < n; i++) begin
      r = (r == 6'd5) ? 6'd1 : r + 6'd1;
    end
    return r;
  endfunction

  // Pop the scoreboard when the DUT reports a result.
  task automatic sb_observe();
    sb_t item;
    if (done || error) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        item = sb_q.pop_front();
        check("sb_kind_error", {31'd0, error}, {31'd0, item.err});
        check("sb_final_model", {26'd0, current_half_divisor}, {26'd0, item.model});
      end
    end
  endtask

  // Issue one request and check every cycle until the controller is idle again.
  task automatic run_req(input logic [5:0] req, input bit exp_err, input int exp_n,
                         input logic [5:0] exp_model, input bit intrude);
    int lat;
    logic [5:0] start;
    bit e_step, e_busy, e_done, e_err;
    logic [5:0] e_cur;
    start = model_q;
    lat   = exp_err ? 1 : exp_n * 8 + 1;
    @(negedge clock_in);
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_half_divisor = req;
    sb_q.push_back('{err: exp_err, model: exp_model});
    for (int k = 0; k <= lat; k++) begin
      @(negedge clock_in);
      e_step = !exp_err && (k < exp_n * 8) && ((k % 8) < 4);
      e_busy = !exp_err && (k < lat);
      e_done = !exp_err && (k == lat - 1);
      e_err  = exp_err && (k == 0);
      e_cur  = exp_err ? start : adv(start, (k < exp_n * 8) ? (k / 8 + 1) : exp_n);
      check("step_divisor", {31'd0, step_divisor}, {31'd0, e_step});
      check("busy", {31'd0, busy}, {31'd0, e_busy});
      check("req_ready", {31'd0, req_ready}, {31'd0, !e_busy});
      check("done", {31'd0, done}, {31'd0, e_done});
      check("error", {31'd0, error}, {31'd0, e_err});
      check("current_half_divisor", {26'd0, current_half_divisor}, {26'd0, e_cur});
      sb_observe();
      req_valid = intrude && (k >= 2) && (k <= 5);
      req_half_divisor = intrude ? 6'd1 : req;
    end
    model_q = exp_model;
  endtask

  initial begin
    vecs[0]  = '{req: 6'd3,  exp_err: 1'b0, exp_n: 2, exp_model: 6'd3};
    vecs[1]  = '{req: 6'd4,  exp_err: 1'b0, exp_n: 1, exp_model: 6'd4};
    vecs[2]  = '{req: 6'd2,  exp_err: 1'b0, exp_n: 3, exp_model: 6'd2};
    vecs[3]  = '{req: 6'd2,  exp_err: 1'b0, exp_n: 0, exp_model: 6'd2};
    vecs[4]  = '{req: 6'd0,  exp_err: 1'b1, exp_n: 0, exp_model: 6'd2};
    vecs[5]  = '{req: 6'd6,  exp_err: 1'b1, exp_n: 0, exp_model: 6'd2};
    vecs[6]  = '{req: 6'd1,  exp_err: 1'b0, exp_n: 4, exp_model: 6'd1};
    vecs[7]  = '{req: 6'd1,  exp_err: 1'b0, exp_n: 0, exp_model: 6'd1};
    vecs[8]  = '{req: 6'd5,  exp_err: 1'b0, exp_n: 4, exp_model: 6'd5};
    vecs[9]  = '{req: 6'd63, exp_err: 1'b1, exp_n: 0, exp_model: 6'd5};
    vecs[10] = '{req: 6'd1,  exp_err: 1'b0, exp_n: 1, exp_model: 6'd1};

    // Reset state.
    repeat (2) @(negedge clock_in);
    check("rst_step", {31'd0, step_divisor}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_model", {26'd0, current_half_divisor}, 32'd1);
    reset = 1'b0;
    @(negedge clock_in);
    check("rst_ready_after", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 11; i++) begin
      run_req(vecs[i].req, vecs[i].exp_err, vecs[i].exp_n, vecs[i].exp_model, 1'b0);
    end

    // Requests while busy are ignored: 1 -> 3 still takes two steps.
    run_req(6'd3, 1'b0, 2, 6'd3, 1'b1);

    // Reset in the middle of a high phase.
    @(negedge clock_in);
    req_valid = 1'b1;
    req_half_divisor = 6'd5;
    sb_q.push_back('{err: 1'b0, model: 6'd5});
    @(negedge clock_in);
    req_valid = 1'b0;
    @(negedge clock_in);
    check("midhigh_step_before", {31'd0, step_divisor}, 32'd1);
    check("midhigh_model_before", {26'd0, current_half_divisor}, 32'd4);
    #2 reset = 1'b1;
    #1;
    check("midhigh_step_dropped", {31'd0, step_divisor}, 32'd0);
    check("midhigh_model_reset", {26'd0, current_half_divisor}, 32'd1);
    check("midhigh_busy", {31'd0, busy}, 32'd0);
    sb_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clock_in);
      check("midhigh_no_done", {31'd0, done}, 32'd0);
    end
    reset = 1'b0;
    model_q = 6'd1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock_in);
      check("post_reset_no_done", {31'd0, done}, 32'd0);
      check("post_reset_no_step", {31'd0, step_divisor}, 32'd0);
    end
    run_req(6'd3, 1'b0, 2, 6'd3, 1'b0);

    check("sb_empty_at_end", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
